// File: rtl/majority_pkg.sv
// Shared sizing and types for the majority sampler, detector and their benches.
// Sample triple plus saturating fill count; purely combinational helpers.
`timescale 1ns/1ps
package majority_pkg;

    localparam int NSAMP  = 3;
    localparam int FILL_W = 2;

    typedef logic [FILL_W-1:0] fill_t;

    localparam fill_t FILL_FULL = fill_t'(NSAMP);

    typedef struct packed {
        logic a;
        logic b;
        logic c;
    } triple_t;

    function automatic fill_t fill_sat_inc(input fill_t f);
        return (f == FILL_FULL) ? f : fill_t'(f + 1'b1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
// Latency: 2 clocks from d_i to q_o; no flow control.
`timescale 1ns/1ps
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/majority_sampler.sv
// Samples a synchronised async input every DIV clocks into a 3-deep history for a voter.
// Latency: 2 clocks sync plus up to DIV clocks to reach a; all outputs come straight from flops.
`timescale 1ns/1ps
module majority_sampler
    import majority_pkg::*;
#(
    parameter int DIV_WIDTH = 16,
    parameter int DIV       = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic en,
    output logic a,
    output logic b,
    output logic c,
    output logic samples_valid,
    output logic sample_strb
);

    localparam logic [DIV_WIDTH-1:0] CNT_LAST = DIV_WIDTH'(DIV - 1);

    logic                 din_s;
    logic                 tick;
    logic [DIV_WIDTH-1:0] cnt_q,   cnt_d;
    fill_t                fill_q,  fill_d;
    triple_t              smp_q,   smp_d;
    logic                 valid_q, valid_d;
    logic                 strb_q,  strb_d;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (din),
        .q_o (din_s)
    );

    assign tick = en && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        smp_d   = smp_q;
        valid_d = valid_q;
        strb_d  = strb_q;
        if (!en) begin
            // History is kept visible but no longer counts as fresh.
            cnt_d   = '0;
            fill_d  = '0;
            valid_d = 1'b0;
            strb_d  = 1'b0;
        end else begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick) begin
                smp_d  = '{a: din_s, b: smp_q.a, c: smp_q.b};
                fill_d = fill_sat_inc(fill_q);
            end
            valid_d = (fill_d == FILL_FULL);
            strb_d  = tick && (fill_d == FILL_FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            fill_q  <= '0;
            smp_q   <= '0;
            valid_q <= 1'b0;
            strb_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            smp_q   <= smp_d;
            valid_q <= valid_d;
            strb_q  <= strb_d;
        end
    end

    assign a             = smp_q.a;
    assign b             = smp_q.b;
    assign c             = smp_q.c;
    assign samples_valid = valid_q;
    assign sample_strb   = strb_q;

endmodule
